// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - shared types and constants for the sequenced 8x8 multiplier
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LOAD_A_BIT  = 0;
  localparam int START_BIT   = 1;
  localparam int OUT_SEL_BIT = 2;
  localparam int CLEAR_BIT   = 3;
  localparam int BUSY_BIT    = 4;
  localparam int DONE_BIT    = 5;
  localparam int OVF_BIT     = 6;

  localparam logic [7:0] UIO_OE_VAL = 8'hF0;
  localparam int         STEPS      = 4;

endpackage

// File: rtl/mul4x4_array.sv
// rtl/mul4x4_array.sv - combinational 4x4 unsigned array multiplier (AND gates + ripple full-adder rows)
module mul4x4_array (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [3:0] row_sum;
  logic [3:0] row_out;
  logic       fa_c;
  logic       fa_x;
  logic       fa_y;

  // Each row adds the next shifted partial product to the upper bits of the previous row.
  always_comb begin
    p       = '0;
    row_out = '0;
    fa_c    = 1'b0;
    fa_x    = 1'b0;
    fa_y    = 1'b0;
    p[0]    = a[0] & b[0];
    row_sum = {1'b0, a[3:1] & {3{b[0]}}};
    for (int i = 1; i < 4; i++) begin
      fa_c = 1'b0;
      for (int j = 0; j < 4; j++) begin
        fa_x       = row_sum[j];
        fa_y       = a[j] & b[i];
        row_out[j] = fa_x ^ fa_y ^ fa_c;
        fa_c       = (fa_x & fa_y) | (fa_c & (fa_x ^ fa_y));
      end
      p[i]    = row_out[0];
      row_sum = {fa_c, row_out[3:1]};
    end
    p[7:4] = row_sum;
  end

endmodule

// File: rtl/tt_um_mult8_seq_hhrb98.sv
// rtl/tt_um_mult8_seq_hhrb98.sv - sequenced 8x8 multiplier top; MULT_SEQ_ACC_EN selects accumulate (MAC) mode
module tt_um_mult8_seq_hhrb98
  import mult_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t      state, state_nx;
  logic [7:0]  op_a, op_a_nx;
  logic [7:0]  op_b, op_b_nx;
  logic [15:0] result, result_nx;
  logic [1:0]  step, step_nx;
  logic        ovf, ovf_nx;
  logic        prev_load_a, prev_start, prev_clear;

  logic        load_a_rise, start_rise, clear_rise;
  logic [3:0]  core_a, core_b;
  logic [7:0]  core_p;
  logic [3:0]  shamt;
  logic [15:0] pp_shift;
  logic [15:0] sum_lo;
  logic        carry;
  logic        busy, done;
  logic        unused_ok;

  assign unused_ok   = &{1'b0, ena, uio_in[7:4]};
  assign load_a_rise = uio_in[LOAD_A_BIT] & ~prev_load_a;
  assign start_rise  = uio_in[START_BIT]  & ~prev_start;
  assign clear_rise  = uio_in[CLEAR_BIT]  & ~prev_clear;

  always_comb begin
    core_a = op_a[3:0];
    core_b = op_b[3:0];
    shamt  = 4'd0;
    case (step)
      2'd0: begin core_a = op_a[3:0]; core_b = op_b[3:0]; shamt = 4'd0; end
      2'd1: begin core_a = op_a[7:4]; core_b = op_b[3:0]; shamt = 4'd4; end
      2'd2: begin core_a = op_a[3:0]; core_b = op_b[7:4]; shamt = 4'd4; end
      default: begin core_a = op_a[7:4]; core_b = op_b[7:4]; shamt = 4'd8; end
    endcase
  end

  mul4x4_array u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  assign pp_shift        = 16'(core_p) << shamt;
  assign {carry, sum_lo} = {1'b0, result} + {1'b0, pp_shift};

  always_comb begin
    state_nx  = state;
    op_a_nx   = op_a;
    op_b_nx   = op_b;
    result_nx = result;
    step_nx   = step;
    ovf_nx    = ovf;
    if (clear_rise) begin
      state_nx  = IDLE;
      result_nx = '0;
      ovf_nx    = 1'b0;
      step_nx   = '0;
    end else begin
      case (state)
        MUL: begin
          result_nx = sum_lo;
`ifdef MULT_SEQ_ACC_EN
          ovf_nx    = ovf | carry;
`endif
          step_nx   = step + 2'd1;
          if (step == 2'(STEPS - 1)) state_nx = DONE;
        end
        default: begin
          if (load_a_rise) op_a_nx = ui_in;
          if (start_rise) begin
            op_b_nx  = ui_in;
            step_nx  = '0;
            state_nx = MUL;
`ifndef MULT_SEQ_ACC_EN
            result_nx = '0;
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      result      <= '0;
      step        <= '0;
      ovf         <= 1'b0;
      prev_load_a <= 1'b0;
      prev_start  <= 1'b0;
      prev_clear  <= 1'b0;
    end else begin
      state       <= state_nx;
      op_a        <= op_a_nx;
      op_b        <= op_b_nx;
      result      <= result_nx;
      step        <= step_nx;
      ovf         <= ovf_nx;
      prev_load_a <= uio_in[LOAD_A_BIT];
      prev_start  <= uio_in[START_BIT];
      prev_clear  <= uio_in[CLEAR_BIT];
    end
  end

  assign busy   = (state == MUL);
  assign done   = (state == DONE);
  assign uo_out = uio_in[OUT_SEL_BIT] ? result[15:8] : result[7:0];
  assign uio_oe = UIO_OE_VAL;

  always_comb begin
    uio_out           = '0;
    uio_out[BUSY_BIT] = busy;
    uio_out[DONE_BIT] = done;
    uio_out[OVF_BIT]  = ovf;
  end

endmodule

// File: doc/tt_um_mult8_seq_hhrb98.md
# tt_um_mult8_seq_hhrb98

Sequenced 8x8 unsigned multiplier for the TinyTapeout tile. It time-shares one combinational 4x4 array multiplier core over four clock cycles, one 4-bit partial product per cycle, and sums the partial products into a 16-bit result register. Operands are loaded byte-wise through the dedicated inputs. Control strobes and status use the bidirectional pins, and the 16-bit result is read one byte at a time on the dedicated outputs.

## Interface
- No parameters.
- clk  input  1  tile clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- ena  input  1  tile enable; unused
- ui_in  input  8  operand byte, captured by the load strobes
- uio_in  input  8  control strobes, synchronous to clk:
  - [0] load_a
  - [1] load_b_start
  - [2] out_sel (0 = low byte, 1 = high byte)
  - [3] clear
  - [7:4] ignored
- uo_out  output  8  out_sel ? result[15:8] : result[7:0]; combinational mux of the result register
- uio_out  output  8  status:
  - [4] busy
  - [5] done
  - [6] ovf
  - [3:0] and [7] are 0
- uio_oe  output  8  constant 8'hF0

## Operation
- Strobe detection: uio_in[0], [1] and [3] each have a previous-value register (reset 0). An action fires on a rising edge, i.e. current=1 and prev=0. A strobe already high at reset release counts as a rising edge.
- Registers: A[7:0], B[7:0], result[15:0], step[1:0], state, ovf.
- States: IDLE, MUL, DONE.
- IDLE or DONE:
  - load_a edge: A <= ui_in.
  - load_b_start edge: B <= ui_in; step <= 0; state <= MUL; result <= 0 (see Configuration).
  - Both edges in the same cycle: A and B both take ui_in, giving a square.
- MUL: each cycle adds one partial product P from the mul4x4 core, zero-extended and shifted, into result:
  - step 0: A[3:0]*B[3:0], shift 0
  - step 1: A[7:4]*B[3:0], shift 4
  - step 2: A[3:0]*B[7:4], shift 4
  - step 3: A[7:4]*B[7:4], shift 8
  - step increments each cycle; after step 3, state <= DONE.
- Arithmetic: 17-bit sum, result <= sum[15:0]. Without accumulation the carry out is provably 0.
- load_a and load_b_start edges while in MUL are ignored. Operands stay stable for the whole operation.
- clear edge in any state, including mid-MUL: state <= IDLE, result <= 0, ovf <= 0, step <= 0. A and B are kept. clear takes priority over simultaneous load or start edges.
- Reset mid-operation: everything returns to reset values immediately.
- busy = (state == MUL). done = (state == DONE); done stays high until the next start or clear.

## Timing
- Reset values: A=0, B=0, result=0, step=0, state=IDLE, ovf=0, edge registers=0. This gives uo_out=0, uio_out=0, uio_oe=8'hF0.
- E0 is the clock edge that samples the load_b_start rising edge. After E0: busy=1.
- E1..E4 add steps 0..3. After E4: busy=0, done=1, and result holds the final product.
- Latency is 4 cycles from E0 to a valid result. A new operation can start on the edge after done rises.
- uo_out follows out_sel in the same cycle. During MUL it shows the partial sum.

## Configuration
- MULT_SEQ_ACC_EN defined:
  - A start does not clear result, so each product accumulates into result (MAC mode).
  - A carry out of bit 15 sets sticky ovf (uio_out[6]). Only clear or reset clears ovf.
- MULT_SEQ_ACC_EN undefined:
  - A start clears result to 0.
  - ovf is tied to 0.

## Structure
- Package mult_seq_pkg holds:
  - the state enum (IDLE, MUL, DONE)
  - uio bit-index constants (LOAD_A_BIT=0, START_BIT=1, OUT_SEL_BIT=2, CLEAR_BIT=3, BUSY_BIT=4, DONE_BIT=5, OVF_BIT=6)
  - UIO_OE_VAL=8'hF0
  - STEPS=4
- One sub-module, mul4x4_array: a combinational 4x4 unsigned array multiplier built from AND gates and full adders, with ports a[3:0], b[3:0], p[7:0].
- Top level contains the operand mux driven by step, the shifter, the adder, the FSM and the strobe edge detectors.

## Test plan
- A=0x12, B=0x34 start -> busy for exactly 4 cycles, then done=1; result 0x03A8 (out_sel=0: 0xA8, out_sel=1: 0x03).
- A=0xFF, B=0xFF -> 0xFE01. A=0x00, B=0xAB -> 0x0000 with done=1.
- load_a and load_b_start rising together with ui_in=0x0F -> 0x00E1.
- During MUL, pulse load_a with ui_in=0x99 and re-pulse start -> both ignored; with A=0x12, B=0x34 the result is still 0x03A8.
- clear edge at step 2 -> busy=0, done=0, result=0 on the next cycle; reset asserted mid-MUL -> all outputs 0 immediately.
- With MULT_SEQ_ACC_EN: 0xFF*0xFF twice -> 0xFE01 after the first, then 0xFC02 with ovf=1; clear -> 0x0000, ovf=0.
